nav_sequencer: RTL



---
 rtl/nav_cmd_if.sv | 10 +
 rtl/nav_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/nav_cmd_if.sv
// Command stream between a requester and the nav_sequencer: a valid/ready
// handshake carrying a 3-bit opcode.
interface nav_cmd_if;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_op, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, output cmd_ready);
endinterface

// File: rtl/nav_sequencer.sv
// Sequencing controller for the axis-position datapath: one-hot velocity and
// position-source selects, plus the warp charge / jump / cooldown sequence.
module nav_sequencer #(
  parameter int unsigned CHARGE_CYCLES   = 8,
  parameter int unsigned COOLDOWN_CYCLES = 16,
  parameter int unsigned CW              = 8
) (
  input  logic       clk,
  input  logic       reset,
  nav_cmd_if.slave   cmd,
  output logic [3:0] mode_selector,
  output logic [3:0] pos_selector,
  output logic       warp_active,
  output logic       busy,
  output logic       cmd_error,
  output logic [7:0] warp_count
);

  typedef enum logic [2:0] {
    S_CLEAR, S_CRUISE, S_CHARGE, S_WARP, S_COOLDOWN
  } state_e;

  typedef enum logic [2:0] {
    OP_RESET_POS = 3'd0,
    OP_ATTACK    = 3'd1,
    OP_DEFENSE   = 3'd2,
    OP_STEALTH   = 3'd3,
    OP_WARP      = 3'd4,
    OP_HALT      = 3'd5
  } op_e;

  localparam logic [3:0]    MODE_ZERO    = 4'b0001;
  localparam logic [3:0]    MODE_ATTACK  = 4'b0010;
  localparam logic [3:0]    MODE_DEFENSE = 4'b0100;
  localparam logic [3:0]    MODE_STEALTH = 4'b1000;
  localparam logic [3:0]    POS_CLEAR    = 4'b0001;
  localparam logic [3:0]    POS_INTEG    = 4'b0010;
  localparam logic [3:0]    POS_WARP     = 4'b0100;
  localparam logic [CW-1:0] CHARGE_LOAD  = CW'(CHARGE_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LOAD    = CW'(COOLDOWN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [CW-1:0] counter_q, counter_d;
  logic [3:0]  cruise_mode_q, cruise_mode_d;
  logic [7:0]  warp_count_q, warp_count_d;
  logic        cmd_error_q, cmd_error_d;
  logic        accept;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_CLEAR;
      counter_q     <= '0;
      cruise_mode_q <= MODE_ZERO;
      warp_count_q  <= '0;
      cmd_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      cruise_mode_q <= cruise_mode_d;
      warp_count_q  <= warp_count_d;
      cmd_error_q   <= cmd_error_d;
    end
  end

  assign accept = cmd.cmd_valid && (state_q == S_CRUISE);

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    cruise_mode_d = cruise_mode_q;
    warp_count_d  = warp_count_q;
    cmd_error_d   = 1'b0;
    unique case (state_q)
      S_CLEAR: state_d = S_CRUISE;
      S_CRUISE: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_RESET_POS: state_d = S_CLEAR;
            OP_ATTACK:    cruise_mode_d = MODE_ATTACK;
            OP_DEFENSE:   cruise_mode_d = MODE_DEFENSE;
            OP_STEALTH:   cruise_mode_d = MODE_STEALTH;
            OP_HALT:      cruise_mode_d = MODE_ZERO;
            OP_WARP: begin
              state_d   = S_CHARGE;
              counter_d = CHARGE_LOAD;
            end
            default:      cmd_error_d = 1'b1;
          endcase
        end
      end
      S_CHARGE: begin
        if (counter_q == '0) state_d = S_WARP;
        else                 counter_d = counter_q - 1'b1;
      end
      S_WARP: begin
        state_d   = S_COOLDOWN;
        counter_d = COOL_LOAD;
        if (warp_count_q != 8'hFF) warp_count_d = warp_count_q + 8'd1;
      end
      S_COOLDOWN: begin
        if (counter_q == '0) state_d = S_CRUISE;
        else                 counter_d = counter_q - 1'b1;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Moore decode: outputs depend on registered state only.
  always_comb begin
    mode_selector = MODE_ZERO;
    pos_selector  = POS_INTEG;
    cmd.cmd_ready = 1'b0;
    busy          = 1'b1;
    warp_active   = 1'b0;
    unique case (state_q)
      S_CLEAR:  pos_selector = POS_CLEAR;
      S_CRUISE: begin
        mode_selector = cruise_mode_q;
        cmd.cmd_ready = 1'b1;
        busy          = 1'b0;
      end
      S_WARP: begin
        pos_selector = POS_WARP;
        warp_active  = 1'b1;
      end
      default: ;
    endcase
  end

  assign cmd_error  = cmd_error_q;
  assign warp_count = warp_count_q;

endmodule
